// File: rtl/spi_pkg.sv
// Shared SPI definitions: controller FSM states and the Mode-0 clock polarity/phase.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SCK_HI,
    ST_SCK_LO,
    ST_CS_GAP
  } spi_state_e;

  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_sck_tick.sv
// Half-period timer: counts enabled cycles and pulses tick_o on the SCK_HALF-th one.
module spi_sck_tick #(
  parameter int unsigned SCK_HALF = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic load_i,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [7:0] TERMINAL = 8'(SCK_HALF - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign tick_o = en_i && (cnt_q == TERMINAL);

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? 8'd0 : cnt_q + 8'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_controller.sv
// SPI Mode-0 master: one DATA_WIDTH-bit full-duplex transfer per start, MSB first,
// with optional chip-select hold so consecutive transfers share one CS window.
module spi_controller
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SCK_HALF   = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  hold_cs_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  spi_cs_no,
  output logic                  spi_sck_o,
  output logic                  spi_sd_o,
  input  logic                  spi_sd_i
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  spi_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0]      bit_q, bit_d;
  logic                  hold_q, hold_d;
  logic                  last_q, last_d;
  logic                  cs_n_q, cs_n_d;
  logic                  sck_q, sck_d;
  logic                  sdo_q, sdo_d;
  logic                  valid_q, valid_d;
  logic                  ready_q, ready_d;
  logic                  tick_load, tick_en, tick;

  spi_sck_tick #(.SCK_HALF(SCK_HALF)) u_tick (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (tick_load),
    .en_i    (tick_en),
    .tick_o  (tick)
  );

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    data_d    = data_q;
    bit_d     = bit_q;
    hold_d    = hold_q;
    last_d    = last_q;
    cs_n_d    = cs_n_q;
    sck_d     = sck_q;
    sdo_d     = sdo_q;
    valid_d   = 1'b0;
    tick_load = 1'b0;
    tick_en   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Also the CS-hold state: cs_n_q simply stays low until the next accept.
        if (start_i) begin
          state_d   = ST_SETUP;
          tx_d      = data_i;
          hold_d    = hold_cs_i;
          bit_d     = '0;
          last_d    = 1'b0;
          cs_n_d    = 1'b0;
          sck_d     = SPI_CPOL;
          sdo_d     = data_i[DATA_WIDTH-1];
          tick_load = 1'b1;
        end
      end

      ST_SETUP, ST_SCK_LO: begin
        if (state_q == ST_SCK_LO && last_q) begin
          state_d   = ST_CS_GAP;
          cs_n_d    = 1'b1;
          sdo_d     = 1'b0;
          last_d    = 1'b0;
          tick_load = 1'b1;
        end else begin
          tick_en = 1'b1;
          if (tick) begin
            state_d = ST_SCK_HI;
            sck_d   = ~SPI_CPOL;
            if (SPI_CPHA == 1'b0) begin
              rx_d = (rx_q << 1) | DATA_WIDTH'(spi_sd_i);
            end
          end
        end
      end

      ST_SCK_HI: begin
        tick_en = 1'b1;
        if (tick) begin
          sck_d = SPI_CPOL;
          if (bit_q == LAST_BIT) begin
            valid_d = 1'b1;
            data_d  = rx_q;
            sdo_d   = 1'b0;
            if (hold_q) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_SCK_LO;
              last_d  = 1'b1;
            end
          end else begin
            state_d = ST_SCK_LO;
            bit_d   = bit_q + 1'b1;
            tx_d    = tx_q << 1;
            sdo_d   = tx_d[DATA_WIDTH-1];
          end
        end
      end

      ST_CS_GAP: begin
        tick_en = 1'b1;
        if (tick) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      data_q  <= '0;
      bit_q   <= '0;
      hold_q  <= 1'b0;
      last_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      sck_q   <= SPI_CPOL;
      sdo_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      data_q  <= data_d;
      bit_q   <= bit_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      cs_n_q  <= cs_n_d;
      sck_q   <= sck_d;
      sdo_q   <= sdo_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign ready_o   = ready_q;
  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign spi_cs_no = cs_n_q;
  assign spi_sck_o = sck_q;
  assign spi_sd_o  = sdo_q;

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: SCK_HALF=2 instance with loopback or Mode-0
// peripheral model, and an SCK_HALF=1 instance for back-to-back starts.
module tb_spi_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       start0 = 1'b0, hold0 = 1'b0;
  logic [7:0] data0 = 8'h00;
  logic       ready0, valid0, cs0, sck0, sdo0, sdi0;
  logic [7:0] data_o0;
  logic       start1 = 1'b0, hold1 = 1'b0;
  logic [7:0] data1 = 8'h00;
  logic       ready1, valid1, cs1, sck1, sdo1, sdi1;
  logic [7:0] data_o1;

  logic       loopback = 1'b1;
  logic [7:0] p_tx = 8'h00, p_rx = 8'h00;
  logic       p_bit = 1'b0, p_prev_sck = 1'b0;
  int         p_cnt = 0;

  assign sdi0 = loopback ? sdo0 : p_bit;
  assign sdi1 = sdo1;

  spi_controller #(.DATA_WIDTH(8), .SCK_HALF(2)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start0), .data_i(data0), .hold_cs_i(hold0),
    .ready_o(ready0), .data_o(data_o0), .valid_o(valid0), .spi_cs_no(cs0),
    .spi_sck_o(sck0), .spi_sd_o(sdo0), .spi_sd_i(sdi0)
  );

  spi_controller #(.DATA_WIDTH(8), .SCK_HALF(1)) dut1 (
    .clk_i(clk), .reset_i(reset), .start_i(start1), .data_i(data1), .hold_cs_i(hold1),
    .ready_o(ready1), .data_o(data_o1), .valid_o(valid1), .spi_cs_no(cs1),
    .spi_sck_o(sck1), .spi_sd_o(sdo1), .spi_sd_i(sdi1)
  );

  // Mode-0 peripheral: samples SDO on SCK rise, presents the next bit on SCK fall.
  always @(posedge sck0 or negedge sck0 or negedge cs0) begin
    if (sck0 && !p_prev_sck) begin
      p_rx  = {p_rx[6:0], sdo0};
      p_cnt = p_cnt + 1;
    end else if (!sck0 && p_prev_sck) begin
      if (p_cnt < 8) p_bit = p_tx[3'(7 - p_cnt)];
    end else begin
      p_cnt = 0;
      p_rx  = 8'h00;
      p_bit = p_tx[7];
    end
    p_prev_sck = sck0;
  end

  // Line-protocol monitors: SDO frozen while SCK high, SDO low while CS deasserted.
  int   sdo_hi_viol = 0, sdo_cs_viol = 0;
  logic m_sck0 = 1'b0, m_sdo0 = 1'b0, m_sck1 = 1'b0, m_sdo1 = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (m_sck0 && sck0 && (sdo0 !== m_sdo0)) sdo_hi_viol = sdo_hi_viol + 1;
      if (m_sck1 && sck1 && (sdo1 !== m_sdo1)) sdo_hi_viol = sdo_hi_viol + 1;
      if (cs0 && sdo0) sdo_cs_viol = sdo_cs_viol + 1;
      if (cs1 && sdo1) sdo_cs_viol = sdo_cs_viol + 1;
    end
    m_sck0 = sck0; m_sdo0 = sdo0; m_sck1 = sck1; m_sdo1 = sdo1;
  end

  int n_checks = 0, n_passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_passed = n_passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Results of one dut transfer observation window (cycle 0 = accept cycle).
  int         valid_cyc, valid_cnt, cs_hi_cyc, ready_cyc, rise_cnt, first_rise, last_rise;
  logic [7:0] rx_at_valid;
  logic       cs_at_1, sdo_at_1;

  task automatic run0(input int ncyc, input int inject_cyc, input logic [7:0] inject_data);
    logic prev;
    valid_cyc = -1; valid_cnt = 0; cs_hi_cyc = -1; ready_cyc = -1;
    rise_cnt = 0; first_rise = -1; last_rise = -1; rx_at_valid = 8'h00;
    prev = sck0;
    for (int c = 1; c <= ncyc; c++) begin
      step();
      start0 = (c == inject_cyc);
      if (c == inject_cyc) data0 = inject_data;
      if (c == 1) begin cs_at_1 = cs0; sdo_at_1 = sdo0; end
      if (valid0) begin
        valid_cnt = valid_cnt + 1;
        if (valid_cyc < 0) valid_cyc = c;
        rx_at_valid = data_o0;
      end
      if (cs0 && cs_hi_cyc < 0) cs_hi_cyc = c;
      if (ready0 && ready_cyc < 0) ready_cyc = c;
      if (sck0 && !prev) begin
        rise_cnt = rise_cnt + 1;
        if (first_rise < 0) first_rise = c;
        last_rise = c;
      end
      prev = sck0;
    end
    start0 = 1'b0;
  endtask

  initial begin
    int   vcnt, v1, v2, cs_break, rises, cs_hi, gap, rdy, rises_first;
    logic [7:0] d1, d2;
    logic rdy_v1, sck_v1, prev;

    // Reset state
    step(); step();
    check("rst_cs", 32'(cs0), 32'd1);
    check("rst_sck", 32'(sck0), 32'd0);
    check("rst_sdo", 32'(sdo0), 32'd0);
    check("rst_valid", 32'(valid0), 32'd0);
    check("rst_data", 32'(data_o0), 32'd0);
    reset = 1'b0;
    step();
    check("rst_ready", 32'(ready0), 32'd1);

    // Loopback 0xA5, SCK_HALF=2, with an ignored start mid-transfer
    loopback = 1'b1; data0 = 8'hA5; hold0 = 1'b0; start0 = 1'b1;
    run0(40, 10, 8'h00);
    check("lb_cs_c1", 32'(cs_at_1), 32'd0);
    check("lb_sdo_c1", 32'(sdo_at_1), 32'd1);
    check("lb_first_rise", 32'(first_rise), 32'd3);
    check("lb_last_rise", 32'(last_rise), 32'd31);
    check("lb_rises", 32'(rise_cnt), 32'd8);
    check("lb_valid_cyc", 32'(valid_cyc), 32'd33);
    check("lb_valid_cnt", 32'(valid_cnt), 32'd1);
    check("lb_data", 32'(rx_at_valid), 32'hA5);
    check("lb_cs_hi", 32'(cs_hi_cyc), 32'd34);
    check("lb_ready", 32'(ready_cyc), 32'd36);

    // Peripheral exchange: TX 0xC3, peripheral returns 0x3C
    loopback = 1'b0; p_tx = 8'h3C; data0 = 8'hC3; start0 = 1'b1;
    run0(40, -1, 8'h00);
    check("per_seen", 32'(p_rx), 32'hC3);
    check("per_bits", 32'(p_cnt), 32'd8);
    check("per_data", 32'(rx_at_valid), 32'h3C);
    check("per_valid_cyc", 32'(valid_cyc), 32'd33);

    // Back-to-back 0x01 (hold) then 0x80 (release)
    loopback = 1'b1; data0 = 8'h01; hold0 = 1'b1; start0 = 1'b1;
    vcnt = 0; v1 = -1; v2 = -1; cs_break = 0; rises = 0; cs_hi = -1;
    d1 = 8'h00; d2 = 8'h00; rdy_v1 = 1'b0; sck_v1 = 1'b1; prev = sck0;
    for (int c = 1; c <= 80; c++) begin
      step();
      start0 = 1'b0;
      if (valid0) begin
        vcnt = vcnt + 1;
        if (vcnt == 1) begin
          v1 = c; d1 = data_o0; rdy_v1 = ready0; sck_v1 = sck0;
          start0 = 1'b1; data0 = 8'h80; hold0 = 1'b0;
        end else begin
          v2 = c; d2 = data_o0;
        end
      end
      if (cs0) begin
        if (v2 < 0) cs_break = cs_break + 1;
        else if (cs_hi < 0) cs_hi = c;
      end
      if (sck0 && !prev) rises = rises + 1;
      prev = sck0;
    end
    start0 = 1'b0;
    check("b2b_v1", 32'(v1), 32'd33);
    check("b2b_ready_v1", 32'(rdy_v1), 32'd1);
    check("b2b_sck_v1", 32'(sck_v1), 32'd0);
    check("b2b_d1", 32'(d1), 32'h01);
    check("b2b_v2", 32'(v2), 32'd66);
    check("b2b_d2", 32'(d2), 32'h80);
    check("b2b_vcnt", 32'(vcnt), 32'd2);
    check("b2b_rises", 32'(rises), 32'd16);
    check("b2b_cs_break", 32'(cs_break), 32'd0);
    check("b2b_cs_hi", 32'(cs_hi), 32'd67);

    // Reset during bit 4 (SCK high in cycles 19..20)
    data0 = 8'h5A; hold0 = 1'b0; start0 = 1'b1;
    step();
    start0 = 1'b0;
    repeat (19) step();
    check("mid_sck_before", 32'(sck0), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_cs", 32'(cs0), 32'd1);
    check("mid_sck", 32'(sck0), 32'd0);
    check("mid_sdo", 32'(sdo0), 32'd0);
    check("mid_valid", 32'(valid0), 32'd0);
    check("mid_data", 32'(data_o0), 32'd0);
    step();
    reset = 1'b0;
    check("mid_ready", 32'(ready0), 32'd1);
    data0 = 8'hFF; start0 = 1'b1;
    run0(40, -1, 8'h00);
    check("post_valid_cnt", 32'(valid_cnt), 32'd1);
    check("post_valid_cyc", 32'(valid_cyc), 32'd33);
    check("post_data", 32'(rx_at_valid), 32'hFF);

    // SCK_HALF=1 with start held high: accepts at 0 and 19
    data1 = 8'h96; hold1 = 1'b0; start1 = 1'b1;
    v1 = -1; v2 = -1; rises = 0; rises_first = 0; gap = 0; rdy = 0;
    d1 = 8'h00; d2 = 8'h00; prev = sck1;
    for (int c = 1; c <= 36; c++) begin
      step();
      if (valid1) begin
        if (v1 < 0) begin v1 = c; d1 = data_o1; end
        else begin v2 = c; d2 = data_o1; end
      end
      if (sck1 && !prev) begin
        rises = rises + 1;
        if (v1 < 0) rises_first = rises_first + 1;
      end
      if (cs1 && !ready1) gap = gap + 1;
      if (ready1) rdy = rdy + 1;
      prev = sck1;
    end
    start1 = 1'b0;
    check("h1_v1", 32'(v1), 32'd17);
    check("h1_v2", 32'(v2), 32'd36);
    check("h1_rises_first", 32'(rises_first), 32'd8);
    check("h1_rises", 32'(rises), 32'd16);
    check("h1_gap", 32'(gap), 32'd1);
    check("h1_ready", 32'(rdy), 32'd1);
    check("h1_d1", 32'(d1), 32'h96);
    check("h1_d2", 32'(d2), 32'h96);

    repeat (4) step();
    check("sdo_stable_hi", 32'(sdo_hi_viol), 32'd0);
    check("sdo_low_cs_hi", 32'(sdo_cs_viol), 32'd0);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 Parameter DATA_WIDTH, default 8: bits per transfer, MSB first.
REQ-002 Parameter SCK_HALF, default 2: system clocks per SCK half-period; legal range 1..255.
REQ-003 clk_i  in  1  system clock; every flop SHALL be clocked on its rising edge.
REQ-004 reset_i  in  1  asynchronous, active-high reset.
REQ-005 start_i  in  1  request a transfer; accepted only in a cycle where ready_o=1.
REQ-006 data_i  in  DATA_WIDTH  byte to transmit; captured in the accept cycle.
REQ-007 hold_cs_i  in  1  captured in the accept cycle; 1 keeps CS asserted after the transfer.
REQ-008 ready_o  out  1  high when a new start_i will be accepted.
REQ-009 data_o  out  DATA_WIDTH  received byte; stable from valid_o until the next valid_o.
REQ-010 valid_o  out  1  one-cycle pulse when data_o is updated.
REQ-011 spi_cs_no  out  1  SPI CS, active low.
REQ-012 spi_sck_o  out  1  SPI SCK, idle low (Mode 0).
REQ-013 spi_sd_o  out  1  SDO toward the peripheral.
REQ-014 spi_sd_i  in  1  SDI from the peripheral.

Function
REQ-015 SHALL implement SPI Mode 0: SDO changes only while SCK is low; SDI sampled on the clk edge that drives SCK high.
REQ-016 FSM states SHALL be IDLE, SETUP, SCK_HI, SCK_LO, CS_GAP.
REQ-017 IDLE: ready_o=1, SCK=0; start_i=1 -> capture data_i/hold_cs_i, go to SETUP.
REQ-018 SETUP (cycle 1 after accept): spi_cs_no=0, spi_sd_o=data_i MSB; after SCK_HALF cycles -> SCK_HI.
REQ-019 SCK_HI: SCK=1, SDI shifted into the receive register on entry; after SCK_HALF cycles -> SCK_LO.
REQ-020 SCK_LO with bits remaining: SCK=0, next TX bit on spi_sd_o on entry; after SCK_HALF cycles -> SCK_HI.
REQ-021 On entry to SCK_LO after the last bit: data_o updated, valid_o=1 for exactly that cycle.
REQ-022 Timing: accept at cycle 0 -> SCK rises at 1+(2k+1)*SCK_HALF for bit k=0..DATA_WIDTH-1; valid_o at 1+2*DATA_WIDTH*SCK_HALF.
REQ-023 After the last bit with hold_cs=1: CS stays low, ready_o=1 in the valid_o cycle; a start_i in that cycle goes directly to SETUP with CS still low.
REQ-024 After the last bit with hold_cs=0: spi_cs_no=1 the cycle after valid_o; CS_GAP holds SCK_HALF cycles with ready_o=0, then IDLE.
REQ-025 In hold state (CS low, no start): SCK=0; start_i=0 with hold continued; a start_i with hold_cs_i=0 ends CS after that transfer.
REQ-026 start_i while ready_o=0 SHALL be ignored, with no effect on data or timing.
REQ-027 Bit counter width SHALL be $clog2(DATA_WIDTH); half-period counter width 8 bits; no wrap beyond terminal counts.
REQ-028 spi_sd_o SHALL be 0 whenever spi_cs_no=1.

Reset
REQ-029 reset_i asserted (including mid-transfer) SHALL immediately force: state IDLE, spi_cs_no=1, spi_sck_o=0, spi_sd_o=0, valid_o=0, data_o=0, ready_o=1 after release.
REQ-030 A transfer interrupted by reset SHALL produce no valid_o; the first clock after release may accept start_i.

Structure
REQ-031 FSM state enum and the Mode-0 CPOL/CPHA constants SHALL live in shared package spi_pkg.
REQ-032 Half-period tick generation SHALL be one sub-module, spi_sck_tick (counter, load/enable, tick output).
REQ-033 All outputs SHALL be registered; no combinational path from spi_sd_i to any output.

Verification
REQ-034 Loopback SDO->SDI, SCK_HALF=2, data_i=0xA5, hold=0 -> valid_o at cycle 33, data_o=0xA5, CS high at 34, ready_o at 36.
REQ-035 Bench peripheral (Mode 0 model) returns 0x3C while TX=0xC3 -> peripheral sees 0xC3, data_o=0x3C, SDO never changes while SCK=1.
REQ-036 Two back-to-back transfers with hold=1 then hold=0 (0x01, 0x80) -> CS low continuously across 16 SCK pulses, two valid_o pulses, CS high only after the second.
REQ-037 reset_i pulsed during bit 4 -> CS=1, SCK=0, SDO=0 same cycle, no valid_o; new transfer 0xFF completes correctly.
REQ-038 start_i held high continuously with hold=0, SCK_HALF=1 -> starts only when ready_o=1, CS gap exactly 1 cycle, 8 SCK pulses each transfer.
